// File: rtl/qmem_decoder.sv
// qmem_decoder: routes one QMEM master to SN slaves by base/mask match.
// Locks onto the selected slave until ack/err; unmapped addresses get a
// one-cycle qm_err; a watchdog cuts off slaves that never respond.
// Ports:
//   clk, rst                     clock, async active-low reset
//   qm_cs/we/sel/adr/dat_w       master request
//   qm_dat_r, qm_ack, qm_err     master response (combinational from slave)
//   qs_cs                        per-slave chip select (combinational decode)
//   qs_we/sel/adr/dat_w          broadcast copies of the master request
//   qs_dat_r, qs_ack, qs_err     per-slave responses
//   ms                           one-hot locked slave, zero outside BUSY
module qmem_decoder #(
    parameter int unsigned QAW = 24,
    parameter int unsigned QDW = 32,
    parameter int unsigned QSW = QDW / 8,
    parameter int unsigned SN  = 2,
    parameter logic [SN-1:0][QAW-1:0] SS = {24'h800000, 24'h000000},
    parameter logic [SN-1:0][QAW-1:0] SM = {24'hF00000, 24'h800000},
    parameter int unsigned TOW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    qm_cs,
    input  logic                    qm_we,
    input  logic [QSW-1:0]          qm_sel,
    input  logic [QAW-1:0]          qm_adr,
    input  logic [QDW-1:0]          qm_dat_w,
    output logic [QDW-1:0]          qm_dat_r,
    output logic                    qm_ack,
    output logic                    qm_err,
    output logic [SN-1:0]           qs_cs,
    output logic                    qs_we,
    output logic [QSW-1:0]          qs_sel,
    output logic [QAW-1:0]          qs_adr,
    output logic [QDW-1:0]          qs_dat_w,
    input  logic [SN-1:0][QDW-1:0]  qs_dat_r,
    input  logic [SN-1:0]           qs_ack,
    input  logic [SN-1:0]           qs_err,
    output logic [SN-1:0]           ms
);

    // Watchdog limit: all ones, i.e. 2^TOW-1 cycles.
    localparam logic [TOW-1:0] TO = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DERR = 2'd2
    } state_t;

    state_t         state;
    logic [TOW-1:0] to_cnt;

    logic           hit;
    logic [SN-1:0]  hit_oh;
    logic           sel_ack;
    logic           sel_err;
    logic [QDW-1:0] sel_dat;
    logic           timeout;

    // Request fields are broadcast unchanged; only cs is per-slave.
    assign qs_we    = qm_we;
    assign qs_sel   = qm_sel;
    assign qs_adr   = qm_adr;
    assign qs_dat_w = qm_dat_w;

    // Address decode: lowest matching index wins.
    always_comb begin
        hit    = 1'b0;
        hit_oh = '0;
        for (int unsigned i = 0; i < SN; i++) begin
            if (!hit && ((qm_adr & SM[i]) == SS[i])) begin
                hit       = 1'b1;
                hit_oh[i] = 1'b1;
            end
        end
    end

    // Response mux from the locked slave; other slaves are masked off.
    always_comb begin
        sel_dat = '0;
        for (int unsigned i = 0; i < SN; i++) begin
            if (ms[i]) sel_dat |= qs_dat_r[i];
        end
        sel_ack = |(qs_ack & ms);
        sel_err = |(qs_err & ms);
        timeout = (to_cnt == TO);
    end

    // Master/slave handshake outputs; everything is forced low while in reset.
    always_comb begin
        qs_cs    = '0;
        qm_ack   = 1'b0;
        qm_err   = 1'b0;
        qm_dat_r = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (qm_cs && hit) qs_cs = hit_oh;
                end
                BUSY: begin
                    qm_dat_r = sel_dat;
                    if (qm_cs) begin
                        // Slave is cut off on the watchdog cycle; a late ack still wins.
                        qs_cs  = timeout ? '0 : ms;
                        qm_ack = sel_ack;
                        qm_err = sel_err | (timeout & ~sel_ack);
                    end
                end
                DERR: begin
                    qm_err = 1'b1;
                end
                default: begin
                    qs_cs = '0;
                end
            endcase
        end
    end

    // State, slave lock and watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ms     <= '0;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (qm_cs) begin
                        if (hit) begin
                            state  <= BUSY;
                            ms     <= hit_oh;
                            to_cnt <= '0;
                        end else begin
                            state <= DERR;
                        end
                    end
                end
                BUSY: begin
                    // Dropped cs, response or watchdog all release the lock.
                    if (!qm_cs || sel_ack || sel_err || timeout) begin
                        state  <= IDLE;
                        ms     <= '0;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
                end
                DERR: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    ms     <= '0;
                    to_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qmem_decoder.sv
// Self-checking bench for qmem_decoder: transaction-level model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_qmem_decoder;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              qm_cs;
    logic              qm_we;
    logic [3:0]        qm_sel;
    logic [23:0]       qm_adr;
    logic [31:0]       qm_dat_w;
    logic [31:0]       qm_dat_r;
    logic              qm_ack;
    logic              qm_err;
    logic [1:0]        qs_cs;
    logic              qs_we;
    logic [3:0]        qs_sel;
    logic [23:0]       qs_adr;
    logic [31:0]       qs_dat_w;
    logic [1:0][31:0]  qs_dat_r;
    logic [1:0]        qs_ack;
    logic [1:0]        qs_err;
    logic [1:0]        ms;

    always #5 clk = ~clk;

    qmem_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .qm_cs    (qm_cs),
        .qm_we    (qm_we),
        .qm_sel   (qm_sel),
        .qm_adr   (qm_adr),
        .qm_dat_w (qm_dat_w),
        .qm_dat_r (qm_dat_r),
        .qm_ack   (qm_ack),
        .qm_err   (qm_err),
        .qs_cs    (qs_cs),
        .qs_we    (qs_we),
        .qs_sel   (qs_sel),
        .qs_adr   (qs_adr),
        .qs_dat_w (qs_dat_w),
        .qs_dat_r (qs_dat_r),
        .qs_ack   (qs_ack),
        .qs_err   (qs_err),
        .ms       (ms)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory map: slave 0 is the lower half, slave 1 is 0x800000-0x8FFFFF.
    function automatic int find_slave(input logic [23:0] a);
        if ((a & 24'h800000) == 24'h000000) return 0;
        if ((a & 24'hF00000) == 24'h800000) return 1;
        return -1;
    endfunction

    // Model state: locked slave (-1 = none), cycles spent locked, error pending.
    int lock = -1;
    int age  = 0;
    bit derr = 1'b0;

    always @(negedge clk) begin
        logic [1:0]  e_cs;
        logic [1:0]  e_ms;
        logic        e_ack;
        logic        e_err;
        logic [31:0] e_dat;
        int          m;
        bit          ack_s;
        bit          err_s;
        bit          to;
        e_cs  = '0;
        e_ack = 1'b0;
        e_err = 1'b0;
        e_dat = '0;
        if (!rst) begin
            lock = -1;
            age  = 0;
            derr = 1'b0;
        end
        e_ms = (lock < 0) ? 2'b00 : 2'(1 << lock);
        if (rst) begin
            if (derr) begin
                e_err = 1'b1;
                derr  = 1'b0;
            end else if (lock < 0) begin
                if (qm_cs) begin
                    m = find_slave(qm_adr);
                    if (m >= 0) begin
                        e_cs = 2'(1 << m);
                        lock = m;
                        age  = 0;
                    end else begin
                        derr = 1'b1;
                    end
                end
            end else begin
                ack_s = qs_ack[lock];
                err_s = qs_err[lock];
                to    = (age == 255);
                e_dat = qs_dat_r[lock];
                if (qm_cs) begin
                    e_ack = ack_s;
                    e_err = err_s || (to && !ack_s);
                    e_cs  = to ? 2'b00 : 2'(1 << lock);
                end
                if (!qm_cs || ack_s || err_s || to) lock = -1;
                else age++;
            end
        end
        check("model_qs_cs", 32'(qs_cs), 32'(e_cs));
        check("model_ms", 32'(ms), 32'(e_ms));
        check("model_qm_ack", 32'(qm_ack), 32'(e_ack));
        check("model_qm_err", 32'(qm_err), 32'(e_err));
        check("model_qm_dat_r", qm_dat_r, e_dat);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_bus();
        qm_cs    = 1'b0;
        qm_we    = 1'b0;
        qm_sel   = '0;
        qm_adr   = '0;
        qm_dat_w = '0;
        qs_ack   = '0;
        qs_err   = '0;
        qs_dat_r = '0;
    endtask

    int n_err;

    initial begin
        idle_bus();
        rst = 1'b0;
        sample();
        check("rst_qs_cs", 32'(qs_cs), 32'h0);
        check("rst_ms", 32'(ms), 32'h0);
        check("rst_ack_err", 32'({qm_ack, qm_err}), 32'h0);
        check("rst_dat_r", qm_dat_r, 32'h0);
        next_cycle();
        rst = 1'b1;
        sample();

        // Read slave 0, ack one cycle later.
        next_cycle();
        qm_cs = 1'b1; qm_adr = 24'h000010; qm_sel = 4'hF;
        sample();
        check("rd0_qs_cs_c0", 32'(qs_cs), 32'h1);
        check("rd0_ms_c0", 32'(ms), 32'h0);
        next_cycle();
        qs_ack = 2'b01; qs_dat_r[0] = 32'hDEADBEEF;
        sample();
        check("rd0_ms_c1", 32'(ms), 32'h1);
        check("rd0_ack_c1", 32'(qm_ack), 32'h1);
        check("rd0_dat_c1", qm_dat_r, 32'hDEADBEEF);
        next_cycle();
        idle_bus();
        sample();
        check("rd0_ms_after", 32'(ms), 32'h0);

        // Write slave 1; a stray ack from slave 0 is ignored.
        next_cycle();
        qm_cs = 1'b1; qm_we = 1'b1; qm_adr = 24'h800004; qm_sel = 4'b0011; qm_dat_w = 32'h12345678;
        sample();
        check("wr1_qs_cs", 32'(qs_cs), 32'h2);
        check("wr1_qs_adr", 32'(qs_adr), 32'h800004);
        check("wr1_qs_sel", 32'(qs_sel), 32'h3);
        check("wr1_qs_we", 32'(qs_we), 32'h1);
        check("wr1_qs_dat_w", qs_dat_w, 32'h12345678);
        next_cycle();
        qs_ack = 2'b01;
        sample();
        check("wr1_stray_ack", 32'(qm_ack), 32'h0);
        check("wr1_ms", 32'(ms), 32'h2);
        next_cycle();
        qs_ack = 2'b10;
        sample();
        check("wr1_ack", 32'(qm_ack), 32'h1);
        next_cycle();
        idle_bus();
        sample();

        // Unmapped address.
        next_cycle();
        qm_cs = 1'b1; qm_adr = 24'h900000;
        sample();
        check("unm_qs_cs_c0", 32'(qs_cs), 32'h0);
        check("unm_err_c0", 32'(qm_err), 32'h0);
        next_cycle();
        sample();
        check("unm_err_c1", 32'(qm_err), 32'h1);
        check("unm_qs_cs_c1", 32'(qs_cs), 32'h0);
        next_cycle();
        idle_bus();
        sample();
        check("unm_err_c2", 32'(qm_err), 32'h0);

        // Slave 1 never acks: watchdog fires 255 cycles after BUSY entry.
        next_cycle();
        qm_cs = 1'b1; qm_adr = 24'h800000;
        n_err = -1;
        for (int n = 0; n < 300 && n_err < 0; n++) begin
            if (n > 0) next_cycle();
            sample();
            if (qm_err) begin
                n_err = n;
                check("to_qs_cs", 32'(qs_cs), 32'h0);
            end
        end
        check("to_err_cycle", 32'(n_err), 32'd256);
        next_cycle();
        idle_bus();
        sample();
        check("to_err_gone", 32'(qm_err), 32'h0);

        // Following access to slave 0 completes normally.
        next_cycle();
        qm_cs = 1'b1; qm_adr = 24'h000020;
        sample();
        next_cycle();
        qs_ack = 2'b01; qs_dat_r[0] = 32'hCAFEF00D;
        sample();
        check("post_to_ack", 32'(qm_ack), 32'h1);
        check("post_to_dat", qm_dat_r, 32'hCAFEF00D);
        next_cycle();
        idle_bus();
        sample();

        // Ack arriving exactly in the timeout cycle wins.
        next_cycle();
        qm_cs = 1'b1; qm_adr = 24'h800008;
        for (int n = 0; n < 255; n++) next_cycle();
        next_cycle();
        qs_ack = 2'b10; qs_dat_r[1] = 32'h0BADF00D;
        sample();
        check("to_race_ack", 32'(qm_ack), 32'h1);
        check("to_race_err", 32'(qm_err), 32'h0);
        next_cycle();
        idle_bus();
        sample();

        // Master drops cs while BUSY: no ack, lock released.
        next_cycle();
        qm_cs = 1'b1; qm_adr = 24'h000030;
        sample();
        next_cycle();
        qm_cs = 1'b0; qs_ack = 2'b01;
        sample();
        check("drop_ack", 32'(qm_ack), 32'h0);
        check("drop_err", 32'(qm_err), 32'h0);
        next_cycle();
        qs_ack = '0;
        sample();
        check("drop_ms", 32'(ms), 32'h0);

        // Back-to-back reads, cs held, then reset mid-BUSY.
        next_cycle();
        qm_cs = 1'b1; qm_adr = 24'h000100;
        sample();
        check("b2b_cs0", 32'(qs_cs), 32'h1);
        next_cycle();
        qs_ack = 2'b01; qs_dat_r[0] = 32'h11111111;
        sample();
        check("b2b_ack0", 32'(qm_ack), 32'h1);
        check("b2b_dat0", qm_dat_r, 32'h11111111);
        next_cycle();
        qm_adr = 24'h800100; qs_ack = '0;
        sample();
        check("b2b_cs1_nobubble", 32'(qs_cs), 32'h2);
        next_cycle();
        qs_ack = 2'b10; qs_dat_r[1] = 32'h22222222;
        sample();
        check("b2b_ack1", 32'(qm_ack), 32'h1);
        check("b2b_dat1", qm_dat_r, 32'h22222222);
        next_cycle();
        qm_adr = 24'h000200; qs_ack = '0;
        sample();
        check("b2b_cs2", 32'(qs_cs), 32'h1);
        next_cycle();
        qs_dat_r[0] = 32'h33333333;
        #1;
        check("b2b_busy_ms", 32'(ms), 32'h1);
        check("b2b_busy_dat", qm_dat_r, 32'h33333333);
        rst = 1'b0;
        #1;
        check("arst_qs_cs", 32'(qs_cs), 32'h0);
        check("arst_ms", 32'(ms), 32'h0);
        check("arst_ack_err", 32'({qm_ack, qm_err}), 32'h0);
        check("arst_dat", qm_dat_r, 32'h0);
        sample();
        next_cycle();
        rst = 1'b1;
        sample();
        check("rst_redecode", 32'(qs_cs), 32'h1);
        next_cycle();
        qs_ack = 2'b01;
        sample();
        check("rst_redecode_ack", 32'(qm_ack), 32'h1);
        next_cycle();
        idle_bus();
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qmem_decoder.md
# qmem_decoder

QMEM address decoder between a single QMEM master port (the output of `qmem_arbiter`) and `SN` QMEM slaves (memory, peripherals). It routes each request to exactly one slave by base/mask match and locks onto that slave until it acks. Unmapped addresses get a one-cycle `qm_err`. Slaves that never ack are cut off by a watchdog, so a stuck peripheral cannot hang the CPU.

## Interface
- `QAW`, 24: address width.
- `QDW`, 32: data width.
- `QSW`, QDW/8: byte-select width.
- `SN`, 2: number of slaves.
- `SS`, {24'h800000, 24'h000000}: packed [SN-1:0][QAW-1:0] slave base addresses; slave i occupies [i*QAW +: QAW].
- `SM`, {24'hF00000, 24'h800000}: packed [SN-1:0][QAW-1:0] slave address masks.
- `TOW`, 8: watchdog counter width; timeout limit TO = 2^TOW-1 cycles.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `qm_cs` in 1: master request; held until ack or err.
- `qm_we` in 1: write enable.
- `qm_sel` in QSW: byte selects.
- `qm_adr` in QAW: address.
- `qm_dat_w` in QDW: write data.
- `qm_dat_r` out QDW: read data from the locked slave.
- `qm_ack` out 1: transfer done.
- `qm_err` out 1: decode error or timeout.
- `qs_cs` out SN: per-slave chip select.
- `qs_we`, `qs_sel`, `qs_adr`, `qs_dat_w` out 1/QSW/QAW/QDW: broadcast copies of the master signals.
- `qs_dat_r` in [SN-1:0][QDW-1:0]: per-slave read data.
- `qs_ack`, `qs_err` in SN: per-slave ack/err.
- `ms` out SN: one-hot locked-slave status; all zero when not BUSY.

## Operation
- Match: slave i matches when `(qm_adr & SM[i]) == SS[i]`. If several match, the lowest index wins.
- States: IDLE, BUSY, DERR.
- IDLE, `qm_cs`=1, match found:
  - `qs_cs[idx]` is driven combinationally in the same cycle.
  - idx is latched into `ms`; next state BUSY.
- IDLE, `qm_cs`=1, no match:
  - no `qs_cs` is asserted; next state DERR.
- DERR: `qm_err`=1 for exactly one cycle, then IDLE.
- BUSY:
  - `qs_cs[ms]` = `qm_cs`.
  - `qm_ack` = `qs_ack[ms]`, combinational.
  - `qm_err` = `qs_err[ms]` OR timeout.
  - `qm_dat_r` = `qs_dat_r[ms]`.
  - On ack or err: back to IDLE; `ms` clears.
- Watchdog: counter `to_cnt` clears on entry to BUSY and increments each BUSY cycle without ack/err. On the cycle it equals TO:
  - `qm_err`=1 and `qs_cs`=0.
  - next state IDLE.
- Master drops `qm_cs` while BUSY (protocol violation): next state IDLE, counter cleared, no ack/err generated.
- `qm_dat_r` = 0 outside BUSY.
- `qs_ack`/`qs_err` from non-selected slaves are ignored.

## Timing
- Reset values: state IDLE, `ms`=0, `to_cnt`=0, `qs_cs`=0, `qm_ack`=0, `qm_err`=0, `qm_dat_r`=0.
- Reset asserted mid-transfer aborts it immediately. After release, a held `qm_cs` is decoded afresh.
- Decode adds no latency. The slave sees `cs` in the same cycle as the master, so `qmem_slave` ack latency passes through unchanged.
- The `qm_cs` → `qs_cs` path through the decode compare is combinational. The slave response → `qm_ack`/`qm_dat_r` path through the `ms` mux is combinational.
- Unmapped access: `qm_err` appears in the cycle after `qm_cs` is first seen, and is one cycle wide.
- Back-to-back transfers: the cycle after ack, state is IDLE. A still-asserted `qm_cs` is decoded that cycle, so there are no idle bubbles.
- Timeout: `qm_err` is asserted exactly TO cycles after entering BUSY; 255 cycles for TOW=8. A slave ack that arrives in the same cycle as the timeout wins: `qm_ack`=1, `qm_err`=0.

## Test plan
- Read 24'h000010 with slave 0 acking one cycle later and returning 32'hDEADBEEF:
  - `qs_cs`=2'b01 in cycle 0, `ms`=2'b01 from cycle 1.
  - `qm_ack`=1 and `qm_dat_r`=32'hDEADBEEF in cycle 1.
- Write 24'h800004, sel 4'b0011, data 32'h12345678:
  - `qs_cs`=2'b10, and the slave sees the same adr/sel/we/dat.
  - `qm_ack` follows slave 1's ack.
- Access 24'h900000 (unmapped):
  - `qs_cs`=0 throughout.
  - `qm_err`=1 for exactly one cycle, the cycle after request; then IDLE.
- Slave 1 never acks on a read of 24'h800000:
  - `qm_err`=1 exactly 255 cycles after BUSY entry, with `qs_cs`=0 that cycle.
  - A following access to slave 0 completes normally.
- Ack in the exact timeout cycle: `qm_ack`=1, `qm_err`=0.
- Back-to-back reads, slave 0 then slave 1, `qm_cs` held:
  - two acks, no idle cycle between the second `cs` and the decode.
  - then `rst` pulsed low mid-BUSY: all outputs 0 asynchronously, `ms`=0.
